pattern_capture: RTL and testbench

Logic-analyzer capture engine: samples `gpio_cap_in` at a programmable rate, packs samples into bytes and writes them sequentially into the external async SRAM from address 0 up to a programmed end address. It is the reverse direction of the pattern generator: SRAM is written from pins instead of read to pins. It sits beside `pattern_gen` under the top level. The top muxes the SRAM bus (`sram_addr`, `sram_data`, `sram_cen`/`oen`/`wen`) to this block whenever `capture_active` is high. Configuration comes from new `lbus_regmap` fields.

---
 rtl/pattern_capture_pkg.sv | 69 ++++++
 rtl/pattern_capture_sram_wr.sv | 93 +++++++++
 rtl/pattern_capture.sv | 179 +++++++++++++++++
 tb/tb_pattern_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_capture_pkg.sv
// Shared types and helpers for the logic-analyzer capture engine.
//   cap_state_t : capture FSM states
//   wr_state_t  : SRAM write engine states
//   cap_cfg_t   : configuration latched on the enable rise
package pattern_capture_pkg;

    localparam int unsigned SRAM_AW      = 19;
    localparam int unsigned CAP_TSEL_MAX = 21;
    localparam int unsigned GPIO_W       = 8;
    localparam int unsigned TSEL_W       = 5;
    localparam int unsigned PCNT_W       = CAP_TSEL_MAX + 2;
    localparam int unsigned PCNT_W1      = PCNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } cap_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_LOW  = 2'd1,
        WR_HOLD = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [SRAM_AW-1:0] end_addr;
        logic [1:0]         wsel;
        logic [TSEL_W-1:0]  tsel;
        logic               trig_en;
        logic [2:0]         trig_sel;
    } cap_cfg_t;

    // Clamp the timestep select so the period never exceeds 2^23 clk.
    function automatic logic [TSEL_W-1:0] sat_tsel(input logic [TSEL_W-1:0] t);
        return (t > TSEL_W'(CAP_TSEL_MAX)) ? TSEL_W'(CAP_TSEL_MAX) : t;
    endfunction

    // Terminal count of the period counter: 2^(t+2)-1 (t already clamped).
    function automatic logic [PCNT_W-1:0] period_mask(input logic [TSEL_W-1:0] t);
        logic [PCNT_W:0] one_hot;
        one_hot = PCNT_W1'(1) << (t + TSEL_W'(2));
        return PCNT_W'(one_hot - PCNT_W1'(1));
    endfunction

    // Index of the final sample in a byte: 8/w - 1.
    function automatic logic [2:0] last_slot(input logic [1:0] wsel);
        case (wsel)
            2'd0:    return 3'd7;
            2'd1:    return 3'd3;
            2'd2:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Shift a new sample in from the top so sample 0 ends up in the low bits.
    function automatic logic [GPIO_W-1:0] pack_sample(input logic [GPIO_W-1:0] acc,
                                                      input logic [GPIO_W-1:0] pins,
                                                      input logic [1:0]        wsel);
        case (wsel)
            2'd0:    return (acc >> 1) | {pins[0],   7'd0};
            2'd1:    return (acc >> 2) | {pins[1:0], 6'd0};
            2'd2:    return (acc >> 4) | {pins[3:0], 4'd0};
            default: return pins;
        endcase
    endfunction

endpackage

// File: rtl/pattern_capture_sram_wr.sv
// Three-cycle SRAM write engine.
//   load/data/last : byte ready (data registered on the load edge), last = final address
//   clear          : abort, strobe high and address back to 0 on the next edge
//   wdata/addr/wen : SRAM write bus
//   wr_done        : one-cycle pulse after the write to the final address
module pattern_capture_sram_wr
    import pattern_capture_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [GPIO_W-1:0]  data,
    input  logic               last,
    output logic [GPIO_W-1:0]  wdata,
    output logic [SRAM_AW-1:0] addr,
    output logic               wen,
    output logic               wr_done
);

    wr_state_t          wr_state, wr_nxt;
    logic               pend, pend_nxt;
    logic               last_q, last_nxt;
    logic [GPIO_W-1:0]  wdata_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic               wen_nxt;
    logic               done_nxt;

    // Data is set up one edge before wen falls; the address steps one edge after wen rises.
    always_comb begin
        wr_nxt    = wr_state;
        pend_nxt  = pend;
        last_nxt  = last_q;
        wdata_nxt = wdata;
        addr_nxt  = addr;
        wen_nxt   = wen;
        done_nxt  = 1'b0;
        if (clear) begin
            wr_nxt   = WR_IDLE;
            pend_nxt = 1'b0;
            wen_nxt  = 1'b1;
            addr_nxt = '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (pend) begin
                        wen_nxt  = 1'b0;
                        pend_nxt = 1'b0;
                        wr_nxt   = WR_LOW;
                    end
                end
                WR_LOW: begin
                    wen_nxt  = 1'b1;
                    done_nxt = last_q;
                    wr_nxt   = WR_HOLD;
                end
                WR_HOLD: begin
                    if (!last_q) begin
                        addr_nxt = addr + SRAM_AW'(1);
                    end
                    wr_nxt = WR_IDLE;
                end
                default: wr_nxt = WR_IDLE;
            endcase
            if (load) begin
                wdata_nxt = data;
                last_nxt  = last;
                pend_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            pend     <= 1'b0;
            last_q   <= 1'b0;
            wdata    <= '0;
            addr     <= '0;
            wen      <= 1'b1;
            wr_done  <= 1'b0;
        end else begin
            wr_state <= wr_nxt;
            pend     <= pend_nxt;
            last_q   <= last_nxt;
            wdata    <= wdata_nxt;
            addr     <= addr_nxt;
            wen      <= wen_nxt;
            wr_done  <= done_nxt;
        end
    end

endmodule

// File: rtl/pattern_capture.sv
// Logic-analyzer capture engine: samples synced GPIO pins at 2^(t+2) clk,
// packs w-bit samples into bytes and writes them to SRAM from address 0 to end.
//   enable_cap/sram_busy        : start (rising edge, bus free) / abort (low)
//   *_sel_cap, trig_*, end_addr : configuration, latched on the enable rise
//   gpio_cap_in                 : asynchronous capture pins
//   capture_active/done         : bus ownership / sticky completion
//   sram_*_cap                  : SRAM address, write data and active-low strobes
module pattern_capture
    import pattern_capture_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_cap,
    input  logic               sram_busy,
    input  logic [23:0]        end_address_cap,
    input  logic [1:0]         num_gpio_sel_cap,
    input  logic [4:0]         timestep_sel_cap,
    input  logic               trig_en_cap,
    input  logic [2:0]         trig_sel_cap,
    input  logic [7:0]         gpio_cap_in,
    output logic               capture_active,
    output logic               capture_done,
    output logic [SRAM_AW-1:0] sram_addr_cap,
    output logic [7:0]         sram_wdata_cap,
    output logic               sram_cen_cap,
    output logic               sram_oen_cap,
    output logic               sram_wen_cap
);

    logic [GPIO_W-1:0] gpio_meta, gpio_sync, gpio_prev;
    logic              en_q1, en_q2;
    logic              en_rise_c;

    cap_state_t        state, state_nxt;
    cap_cfg_t          cfg, cfg_nxt;
    logic [PCNT_W-1:0] pcnt, pcnt_nxt;
    logic [PCNT_W-1:0] pmask_c;
    logic [GPIO_W-1:0] acc, acc_nxt;
    logic [GPIO_W-1:0] packed_c;
    logic [2:0]        slot, slot_nxt;
    logic              sample_c;
    logic              load_c;
    logic              last_c;
    logic              trig_c;
    logic              byte_last_c;
    logic              active_nxt_c;
    logic              clear_c;
    logic              wr_done;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^end_address_cap[23:SRAM_AW];

    // Pin synchronizer, previous synced value for trigger edges, enable edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
            gpio_prev <= '0;
            en_q1     <= 1'b0;
            en_q2     <= 1'b0;
        end else begin
            gpio_meta <= gpio_cap_in;
            gpio_sync <= gpio_meta;
            gpio_prev <= gpio_sync;
            en_q1     <= enable_cap;
            en_q2     <= en_q1;
        end
    end

    assign en_rise_c   = en_q1 & ~en_q2;
    assign trig_c      = gpio_sync[cfg.trig_sel] & ~gpio_prev[cfg.trig_sel];
    assign pmask_c     = period_mask(cfg.tsel);
    assign packed_c    = pack_sample(acc, gpio_sync, cfg.wsel);
    assign byte_last_c = (slot == last_slot(cfg.wsel));
    assign last_c      = (sram_addr_cap == cfg.end_addr);
    assign clear_c     = ~enable_cap;

    // Capture FSM, period counter and sample packing.
    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg;
        pcnt_nxt  = pcnt;
        acc_nxt   = acc;
        slot_nxt  = slot;
        sample_c  = 1'b0;
        load_c    = 1'b0;
        if (!enable_cap) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            acc_nxt   = '0;
            slot_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_rise_c && !sram_busy) begin
                        state_nxt        = ARMED;
                        cfg_nxt.end_addr = end_address_cap[SRAM_AW-1:0];
                        cfg_nxt.wsel     = num_gpio_sel_cap;
                        cfg_nxt.tsel     = sat_tsel(timestep_sel_cap);
                        cfg_nxt.trig_en  = trig_en_cap;
                        cfg_nxt.trig_sel = trig_sel_cap;
                        pcnt_nxt         = '0;
                        acc_nxt          = '0;
                        slot_nxt         = '0;
                    end
                end
                ARMED: begin
                    if (!cfg.trig_en || trig_c) begin
                        state_nxt = RUN;
                        sample_c  = 1'b1;
                        pcnt_nxt  = '0;
                    end
                end
                RUN: begin
                    if (pcnt == pmask_c) begin
                        pcnt_nxt = '0;
                        sample_c = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt + PCNT_W'(1);
                    end
                    if (wr_done) begin
                        state_nxt = DONE;
                    end
                end
                default: ;
            endcase
            if (sample_c) begin
                acc_nxt = packed_c;
                if (byte_last_c) begin
                    load_c   = 1'b1;
                    slot_nxt = '0;
                end else begin
                    slot_nxt = slot + 3'd1;
                end
            end
        end
    end

    assign active_nxt_c = (state_nxt == ARMED) || (state_nxt == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cfg            <= '0;
            pcnt           <= '0;
            acc            <= '0;
            slot           <= '0;
            capture_active <= 1'b0;
            capture_done   <= 1'b0;
            sram_cen_cap   <= 1'b1;
        end else begin
            state          <= state_nxt;
            cfg            <= cfg_nxt;
            pcnt           <= pcnt_nxt;
            acc            <= acc_nxt;
            slot           <= slot_nxt;
            capture_active <= active_nxt_c;
            capture_done   <= (state_nxt == DONE);
            sram_cen_cap   <= ~active_nxt_c;
        end
    end

    // The SRAM is only ever written, so output enable stays deasserted.
    assign sram_oen_cap = 1'b1;

    pattern_capture_sram_wr u_sram_wr (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_c),
        .load    (load_c),
        .data    (packed_c),
        .last    (last_c),
        .wdata   (sram_wdata_cap),
        .addr    (sram_addr_cap),
        .wen     (sram_wen_cap),
        .wr_done (wr_done)
    );

endmodule

// File: tb/tb_pattern_capture.sv
// Directed testbench for pattern_capture with an SRAM write log.
module tb_pattern_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_cap = 1'b0;
    logic        sram_busy = 1'b0;
    logic [23:0] end_address_cap = '0;
    logic [1:0]  num_gpio_sel_cap = '0;
    logic [4:0]  timestep_sel_cap = '0;
    logic        trig_en_cap = 1'b0;
    logic [2:0]  trig_sel_cap = '0;
    logic [7:0]  gpio_cap_in = '0;
    logic        capture_active;
    logic        capture_done;
    logic [18:0] sram_addr_cap;
    logic [7:0]  sram_wdata_cap;
    logic        sram_cen_cap;
    logic        sram_oen_cap;
    logic        sram_wen_cap;

    pattern_capture dut (
        .clk              (clk),
        .reset            (reset),
        .enable_cap       (enable_cap),
        .sram_busy        (sram_busy),
        .end_address_cap  (end_address_cap),
        .num_gpio_sel_cap (num_gpio_sel_cap),
        .timestep_sel_cap (timestep_sel_cap),
        .trig_en_cap      (trig_en_cap),
        .trig_sel_cap     (trig_sel_cap),
        .gpio_cap_in      (gpio_cap_in),
        .capture_active   (capture_active),
        .capture_done     (capture_done),
        .sram_addr_cap    (sram_addr_cap),
        .sram_wdata_cap   (sram_wdata_cap),
        .sram_cen_cap     (sram_cen_cap),
        .sram_oen_cap     (sram_oen_cap),
        .sram_wen_cap     (sram_wen_cap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log: every negedge with wen low is one write cycle.
    logic [18:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];
    always @(negedge clk) begin
        if (sram_wen_cap === 1'b0) begin
            wa_q.push_back(sram_addr_cap);
            wd_q.push_back(sram_wdata_cap);
            wc_q.push_back(cyc);
        end
    end

    int   done_cyc = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (capture_done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (capture_done === 1'b1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] wa_at(input int i);
        return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic start(input logic [1:0] w, input logic [4:0] t, input logic te,
                         input logic [2:0] ts, input logic [23:0] ea, input logic [7:0] pins);
        @(negedge clk);
        num_gpio_sel_cap = w;
        timestep_sel_cap = t;
        trig_en_cap      = te;
        trig_sel_cap     = ts;
        end_address_cap  = ea;
        gpio_cap_in      = pins;
        enable_cap       = 1'b1;
    endtask

    task automatic stop();
        @(negedge clk);
        enable_cap = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (capture_done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(capture_done), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int last_wc;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_active", 32'(capture_active), 32'd0);
        check("rst_done",   32'(capture_done),   32'd0);
        check("rst_addr",   32'(sram_addr_cap),  32'd0);
        check("rst_wdata",  32'(sram_wdata_cap), 32'd0);
        check("rst_strb",   32'({sram_cen_cap, sram_oen_cap, sram_wen_cap}), 32'd7);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // w=8, t=0, untriggered, four bytes
        clear_log();
        start(2'd3, 5'd0, 1'b0, 3'd0, 24'd3, 8'h11);
        repeat (4) @(negedge clk); gpio_cap_in = 8'h22;
        repeat (4) @(negedge clk); gpio_cap_in = 8'h33;
        repeat (4) @(negedge clk); gpio_cap_in = 8'h44;
        wait_done("t1", 40);
        @(negedge clk);
        check("t1_nwr", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), wa_at(i), 32'(i));
            check($sformatf("t1_data%0d", i), wd_at(i), 32'(8'h11 * (i + 1)));
        end
        last_wc = (wc_q.size() > 0) ? wc_q[wc_q.size() - 1] : -100;
        check("t1_done_lat", 32'(done_cyc - last_wc), 32'd2);
        check("t1_addr_hold", 32'(sram_addr_cap), 32'd3);
        check("t1_active",    32'(capture_active), 32'd0);
        check("t1_strb",      32'({sram_cen_cap, sram_oen_cap, sram_wen_cap}), 32'd7);
        stop();
        check("t1_done_clr",  32'(capture_done), 32'd0);

        // w=1, t=0, end=0, bit0 alternating from 1
        start(2'd0, 5'd0, 1'b0, 3'd0, 24'd0, 8'h01);
        for (int k = 1; k < 8; k++) begin
            repeat (4) @(negedge clk);
            gpio_cap_in = (k % 2 == 0) ? 8'h01 : 8'h00;
        end
        wait_done("t2", 40);
        @(negedge clk);
        check("t2_wen_cycles", 32'(wa_q.size()), 32'd1);
        check("t2_data",       wd_at(0), 32'h55);
        check("t2_addr",       wa_at(0), 32'd0);
        stop();

        // Trigger on bit 5, w=4, t=1
        start(2'd2, 5'd1, 1'b1, 3'd5, 24'd0, 8'h0A);
        repeat (20) @(negedge clk);
        check("t3_armed_active", 32'(capture_active), 32'd1);
        check("t3_armed_cen",    32'(sram_cen_cap),   32'd0);
        check("t3_armed_nwr",    32'(wa_q.size()),    32'd0);
        gpio_cap_in = 8'h2B;
        repeat (4) @(negedge clk);
        gpio_cap_in = 8'h25;
        wait_done("t3", 60);
        check("t3_nwr",        32'(wa_q.size()), 32'd1);
        check("t3_first_nib",  wd_at(0) & 32'hF, 32'hB);
        check("t3_data",       wd_at(0), 32'h5B);
        stop();

        // Abort in the wen-low cycle, then restart from address 0
        start(2'd3, 5'd0, 1'b0, 3'd0, 24'd3, 8'h99);
        n = 0;
        while (sram_wen_cap !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_wen_low_seen", 32'(sram_wen_cap), 32'd0);
        enable_cap = 1'b0;
        @(negedge clk);
        check("t4_wen_after",    32'(sram_wen_cap),   32'd1);
        check("t4_active_after", 32'(capture_active), 32'd0);
        check("t4_addr_after",   32'(sram_addr_cap),  32'd0);
        check("t4_cen_after",    32'(sram_cen_cap),   32'd1);
        repeat (2) @(negedge clk);
        clear_log();
        start(2'd3, 5'd0, 1'b0, 3'd0, 24'd1, 8'h66);
        repeat (4) @(negedge clk); gpio_cap_in = 8'h77;
        wait_done("t4r", 40);
        check("t4r_nwr",   32'(wa_q.size()), 32'd2);
        check("t4r_addr0", wa_at(0), 32'd0);
        check("t4r_data0", wd_at(0), 32'h66);
        check("t4r_addr1", wa_at(1), 32'd1);
        check("t4r_data1", wd_at(1), 32'h77);
        stop();

        // Enable rise while the bus is busy is ignored
        sram_busy = 1'b1;
        start(2'd3, 5'd0, 1'b0, 3'd0, 24'd0, 8'hF0);
        repeat (6) @(negedge clk);
        check("t5_busy_active", 32'(capture_active), 32'd0);
        check("t5_busy_cen",    32'(sram_cen_cap),   32'd1);
        sram_busy = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_no_rise_active", 32'(capture_active), 32'd0);
        check("t5_nwr",            32'(wa_q.size()),    32'd0);
        stop();

        // Reset mid-RUN
        start(2'd3, 5'd0, 1'b0, 3'd0, 24'd5, 8'h3C);
        repeat (8) @(negedge clk);
        check("t6_pre_addr",   32'(sram_addr_cap),  32'd1);
        check("t6_pre_active", 32'(capture_active), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_active", 32'(capture_active), 32'd0);
        check("t6_rst_done",   32'(capture_done),   32'd0);
        check("t6_rst_addr",   32'(sram_addr_cap),  32'd0);
        check("t6_rst_wdata",  32'(sram_wdata_cap), 32'd0);
        check("t6_rst_strb",   32'({sram_cen_cap, sram_oen_cap, sram_wen_cap}), 32'd7);
        enable_cap = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();

        // Period at t=3 is 32 clk between bytes
        start(2'd3, 5'd3, 1'b0, 3'd0, 24'd1, 8'h12);
        repeat (16) @(negedge clk); gpio_cap_in = 8'h34;
        wait_done("t7", 200);
        check("t7_nwr", 32'(wa_q.size()), 32'd2);
        check("t7_period", (wc_q.size() > 1) ? 32'(wc_q[1] - wc_q[0]) : 32'hDEAD_BEEF, 32'd32);
        check("t7_data0", wd_at(0), 32'h12);
        check("t7_data1", wd_at(1), 32'h34);
        stop();

        // t=31 saturates to a 2^23 clk period: no second byte for a long time
        start(2'd3, 5'd31, 1'b0, 3'd0, 24'd1, 8'hA5);
        repeat (30000) @(negedge clk);
        check("t8_nwr",    32'(wa_q.size()),    32'd1);
        check("t8_data0",  wd_at(0),            32'hA5);
        check("t8_active", 32'(capture_active), 32'd1);
        check("t8_done",   32'(capture_done),   32'd0);
        stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
